// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with optional packet lock
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_WIDTH      = 2,
  parameter int START_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   uart_transmit,
  output logic [7:0]             uart_tx_byte,
  input  logic                   uart_is_transmitting,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic                   locked,
  output logic                   busy,
  output logic                   start_error,
  output logic                   lock_timeout
);
  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, LOCKED} state_t;
  localparam int TW = 16;
  state_t state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d, grant_q, grant_d, win, sel, idx;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [7:0] byte_q, byte_d;
  logic [TW-1:0] timer_q, timer_d;
  logic locked_q, locked_d, transmit_q, transmit_d, serr_q, serr_d, lto_q, lto_d;
  logic found, load;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    locked_d = locked_q;
    byte_d = byte_q;
    timer_d = timer_q + TW'(1);
    transmit_d = 1'b0;
    ready_d = '0;
    serr_d = 1'b0;
    lto_d = 1'b0;
    sel = state_q == LOCKED ? grant_q : win;
    load = !uart_is_transmitting && (state_q == IDLE ? found : state_q == LOCKED && req_valid[grant_q]);
    case (state_q)
      WAIT_START:
        if (uart_is_transmitting) state_d = WAIT_DONE;
        else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          serr_d = 1'b1;
          locked_d = 1'b0;
          state_d = IDLE;
        end
      WAIT_DONE: begin
        timer_d = '0;
        if (!uart_is_transmitting) state_d = locked_q ? LOCKED : IDLE;
      end
      LOCKED:
        if (!load && LOCK_TIMEOUT != 0 && timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          lto_d = 1'b1;
          locked_d = 1'b0;
          state_d = IDLE;
        end
      default: ;
    endcase
    // the rotation pointer only advances on a fresh arbitration, not inside a locked packet
    if (load) begin
      transmit_d = 1'b1;
      ready_d = NUM_REQ'(1) << sel;
      byte_d = req_data[{sel, 3'b000} +: 8];
      grant_d = sel;
      locked_d = ~req_last[sel];
      ptr_d = state_q == IDLE ? sel : ptr_q;
      timer_d = '0;
      state_d = WAIT_START;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= ID_WIDTH'(NUM_REQ - 1);
      grant_q <= '0;
      locked_q <= 1'b0;
      byte_q <= '0;
      timer_q <= '0;
      transmit_q <= 1'b0;
      ready_q <= '0;
      serr_q <= 1'b0;
      lto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      locked_q <= locked_d;
      byte_q <= byte_d;
      timer_q <= timer_d;
      transmit_q <= transmit_d;
      ready_q <= ready_d;
      serr_q <= serr_d;
      lto_q <= lto_d;
    end
  end
  assign req_ready = ready_q;
  assign uart_transmit = transmit_q;
  assign uart_tx_byte = byte_q;
  assign grant_id = grant_q;
  assign locked = locked_q;
  assign busy = state_q != IDLE;
  assign start_error = serr_q;
  assign lock_timeout = lto_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, packet lock and timeouts
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_last = '0;
  logic [3:0] req_ready;
  logic uart_transmit;
  logic [7:0] uart_tx_byte;
  logic uart_is_transmitting;
  logic [1:0] grant_id;
  logic locked, busy, start_error, lock_timeout;
  logic model_en = 1'b1;
  int cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n;
  uart_tx_arbiter #(.NUM_REQ(4), .ID_WIDTH(2), .START_TIMEOUT(16), .LOCK_TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting), .grant_id(grant_id), .locked(locked),
    .busy(busy), .start_error(start_error), .lock_timeout(lock_timeout)
  );
  always #5 clk = ~clk;
  // uart stand-in: busy for 4 cycles starting the cycle after a strobe, unaffected by rst
  always @(posedge clk) cnt <= (uart_transmit && model_en) ? 4 : (cnt > 0 ? cnt - 1 : 0);
  assign uart_is_transmitting = cnt != 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_strobe(input string tag);
    for (int i = 0; i < 300 && !uart_transmit; i++) @(negedge clk);
    chk(tag, uart_transmit, 1);
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    chk(tag, busy, 0);
  endtask
  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_out", {req_ready, uart_transmit, uart_tx_byte, grant_id, locked, busy, start_error, lock_timeout}, 0);
    req_data[15:8] = 8'hA5;
    req_last[1] = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t1_strobe", uart_transmit, 1);
    chk("t1_byte", uart_tx_byte, 8'hA5);
    chk("t1_ready", req_ready, 4'b0010);
    chk("t1_grant", grant_id, 1);
    chk("t1_locked", locked, 0);
    req_valid = '0;
    @(negedge clk);
    chk("t1_pulse", {uart_transmit, req_ready}, 0);
    wait_idle("t1_idle");
    chk("t1_grant_hold", grant_id, 1);
    do_reset();
    req_data = 32'h43424140;
    req_last = 4'b1111;
    req_valid = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      wait_strobe("t2_strobe");
      chk("t2_grant", grant_id, b % 4);
      chk("t2_ready", req_ready, 4'b0001 << (b % 4));
      chk("t2_byte", uart_tx_byte, 8'h40 + b % 4);
      @(negedge clk);
      chk("t2_pulse", req_ready, 0);
    end
    req_valid = '0;
    wait_idle("t2_idle");
    req_data = 32'h00100077;
    req_last = 4'b0001;
    req_valid = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      wait_strobe("t3_strobe");
      chk("t3_grant", grant_id, 2);
      chk("t3_byte", uart_tx_byte, 8'h10 + b);
      chk("t3_locked", locked, b != 2);
      req_data[23:16] = 8'h11 + b;
      req_last[2] = b == 1;
      if (b == 2) req_valid[2] = 1'b0;
      @(negedge clk);
    end
    wait_strobe("t3_r0_strobe");
    chk("t3_r0_grant", grant_id, 0);
    chk("t3_r0_byte", uart_tx_byte, 8'h77);
    req_valid = '0;
    wait_idle("t3_idle");
    req_data = 32'h33000055;
    req_last = 4'b0001;
    req_valid = 4'b1000;
    wait_strobe("t4_strobe");
    chk("t4_grant", grant_id, 3);
    chk("t4_locked", locked, 1);
    req_valid = 4'b0001;
    for (int i = 0; i < 50 && !uart_is_transmitting; i++) @(negedge clk);
    for (int i = 0; i < 50 && uart_is_transmitting; i++) @(negedge clk);
    n = 0;
    while (!lock_timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_lto_cycles", n, 33);
    chk("t4_unlocked", locked, 0);
    wait_strobe("t4_r0_strobe");
    chk("t4_r0_grant", grant_id, 0);
    chk("t4_r0_byte", uart_tx_byte, 8'h55);
    req_valid = '0;
    wait_idle("t4_idle");
    model_en = 1'b0;
    req_data[15:8] = 8'h99;
    req_last = 4'b0010;
    req_valid = 4'b0010;
    wait_strobe("t5_strobe");
    req_valid = '0;
    n = 0;
    while (!start_error && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_serr_cycles", n, 16);
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_pulse", start_error, 0);
    model_en = 1'b1;
    req_data[15:8] = 8'h21;
    req_last = 4'b0000;
    req_valid = 4'b0010;
    wait_strobe("t6_strobe");
    chk("t6_locked", locked, 1);
    req_valid = '0;
    for (int i = 0; i < 50 && !uart_is_transmitting; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_out", {req_ready, uart_transmit, uart_tx_byte, grant_id, locked, busy, start_error, lock_timeout}, 0);
    req_data = 32'h00002201;
    req_last = 4'b0011;
    req_valid = 4'b0011;
    wait_strobe("t6_next_strobe");
    chk("t6_next_grant", grant_id, 0);
    chk("t6_next_byte", uart_tx_byte, 8'h01);
    req_valid = '0;
    wait_idle("t6_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
